// File: rtl/vec_mem_seq_pkg.sv
// Shared constants and types for the vector load/store sequencer.
package vproc_mem_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 6;
  localparam int LANES  = 4;
  localparam int IDX_W  = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    RESP  = 3'd4
  } vseq_state_t;

  // Lane i occupies bits [i*DATA_W +: DATA_W].
  typedef logic [LANES-1:0][DATA_W-1:0] vec_t;

endpackage

// File: rtl/vec_mem_seq_if.sv
// Command/response bus between the vector execution unit and the sequencer.
interface vec_mem_seq_if;
  import vproc_mem_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_base;
  logic [ADDR_W-1:0] cmd_stride;
  vec_t              wr_vec;
  vec_t              rd_vec;
  logic              rsp_valid;
  logic              rsp_ready;

  modport master (
    output cmd_valid, cmd_write, cmd_base, cmd_stride, wr_vec, rsp_ready,
    input  cmd_ready, rd_vec, rsp_valid
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_base, cmd_stride, wr_vec, rsp_ready,
    output cmd_ready, rd_vec, rsp_valid
  );
endinterface

// File: rtl/vec_mem_seq_addr_gen.sv
// Lane address generator: base + idx*stride, wrapping mod 2**ADDR_W.
module vec_addr_gen
  import vproc_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [ADDR_W-1:0] stride_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [IDX_W-1:0]  idx_o,
  output logic              last_o
);

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] stride_q;
  logic [IDX_W-1:0]  idx_q;

  // Load captures the command; step advances one lane (sum truncates, so 63->0 wraps silently).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      stride_q <= '0;
      idx_q    <= '0;
    end else if (load_i) begin
      addr_q   <= base_i;
      stride_q <= stride_i;
      idx_q    <= '0;
    end else if (step_i) begin
      addr_q   <= addr_q + stride_q;
      idx_q    <= idx_q + 1'b1;
    end
  end

  assign addr_o = addr_q;
  assign idx_o  = idx_q;
  assign last_o = (idx_q == IDX_W'(LANES - 1));

endmodule

// File: rtl/vec_mem_seq.sv
// Vector load/store sequencer: serialises one vector command into per-byte
// accesses on a registered-read dual-port RAM and gathers load bytes back.
module vec_mem_seq
  import vproc_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  vec_mem_seq_if.slave      bus,
  output logic [DATA_W-1:0] ram_data,
  output logic [ADDR_W-1:0] ram_read_addr,
  output logic [ADDR_W-1:0] ram_write_addr,
  output logic              ram_write_enable,
  input  logic [DATA_W-1:0] ram_q
);

  vseq_state_t       state_q, state_d;
  vec_t              wr_q;
  vec_t              rd_q;
  logic [LANES-1:0]  cap_en;
  logic [ADDR_W-1:0] addr;
  logic [IDX_W-1:0]  idx;
  logic              last;
  logic              accept;
  logic              step;

  assign accept = (state_q == IDLE) && bus.cmd_valid;
  assign step   = (state_q == WRITE) || (state_q == READ);

  vec_addr_gen u_addr_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (accept),
    .step_i   (step),
    .base_i   (bus.cmd_base),
    .stride_i (bus.cmd_stride),
    .addr_o   (addr),
    .idx_o    (idx),
    .last_o   (last)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: stores finish on the last lane write, loads need one extra
  // cycle for the registered RAM read of the last lane.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.cmd_valid) state_d = bus.cmd_write ? WRITE : READ;
      WRITE:   if (last) state_d = RESP;
      READ:    if (last) state_d = DRAIN;
      DRAIN:   state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Store data is latched on acceptance so the caller may change wr_vec afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      wr_q <= '0;
    else if (accept) wr_q <= bus.wr_vec;
  end

  // Which lane the RAM output belongs to this cycle: read data lags the address by one.
  always_comb begin
    cap_en = '0;
    if ((state_q == READ) && (idx != '0)) cap_en[idx - 1'b1] = 1'b1;
    if (state_q == DRAIN)                 cap_en[LANES-1]    = 1'b1;
  end

  // Gather register; untouched by stores so the last load result persists.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= '0;
    end else begin
      for (int i = 0; i < LANES; i++)
        if (cap_en[i]) rd_q[i] <= ram_q;
    end
  end

  // RAM port drive; everything is 0 outside the active access state, so the
  // two ports are never active together and reset clears them immediately.
  always_comb begin
    ram_data         = '0;
    ram_read_addr    = '0;
    ram_write_addr   = '0;
    ram_write_enable = 1'b0;
    if (state_q == WRITE) begin
      ram_write_enable = 1'b1;
      ram_write_addr   = addr;
      ram_data         = wr_q[idx];
    end else if (state_q == READ) begin
      ram_read_addr    = addr;
    end
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rd_vec    = rd_q;

endmodule

// File: tb/tb_vec_mem_seq.sv
// Self-checking bench for vec_mem_seq with a behavioural RAM and memory model.
module tb_vec_mem_seq;
  import vproc_mem_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vec_mem_seq_if bus();

  logic [DATA_W-1:0] ram_data;
  logic [ADDR_W-1:0] ram_read_addr;
  logic [ADDR_W-1:0] ram_write_addr;
  logic              ram_write_enable;
  logic [DATA_W-1:0] ram_q;

  vec_mem_seq dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .bus              (bus.slave),
    .ram_data         (ram_data),
    .ram_read_addr    (ram_read_addr),
    .ram_write_addr   (ram_write_addr),
    .ram_write_enable (ram_write_enable),
    .ram_q            (ram_q)
  );

  // ram1: 64x8, write on edge, registered read.
  bit [7:0]    mem [64];
  int unsigned waddr_log[$];
  always @(posedge clk) begin
    if (ram_write_enable) begin
      mem[ram_write_addr] <= ram_data;
      waddr_log.push_back(int'(ram_write_addr));
    end
    ram_q <= mem[ram_read_addr];
  end

  // Reference memory image and bookkeeping.
  bit [7:0]    ref_mem [64];
  logic [31:0] last_rd;
  int          wlog_rd;
  int          checks;
  int          failures;

  typedef struct {
    bit          wr;
    logic [5:0]  base;
    logic [5:0]  stride;
    logic [31:0] wv;
    logic [31:0] exp_rd;
  } vec_rec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int lane_addr(input logic [5:0] b, input logic [5:0] s, input int i);
    return (int'(b) + i * int'(s)) % 64;
  endfunction

  function automatic logic [31:0] model_load(input logic [5:0] b, input logic [5:0] s);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < 4; i++) v[i*8 +: 8] = ref_mem[lane_addr(b, s, i)];
    return v;
  endfunction

  // Issue one command, optionally holding the response and pulsing a stray
  // command during RESP; returns gathered data and edges to rsp_valid.
  task automatic do_cmd(input bit wr, input logic [5:0] b, input logic [5:0] s,
                        input logic [31:0] wv, input int hold,
                        output logic [31:0] rd, output int lat);
    int n;
    n = 0;
    while (!bus.cmd_ready && n < 20) begin @(negedge clk); n++; end
    chk("cmd_ready_before_cmd", bus.cmd_ready, 1);
    @(negedge clk);
    bus.cmd_valid  = 1'b1;
    bus.cmd_write  = wr;
    bus.cmd_base   = b;
    bus.cmd_stride = s;
    bus.wr_vec     = wv;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    chk("cmd_ready_busy", bus.cmd_ready, 0);
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      lat++;
      #1;
      if (bus.rsp_valid) break;
    end
    rd = bus.rd_vec;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      bus.cmd_valid  = (h == 1);
      bus.cmd_write  = 1'b1;
      bus.cmd_base   = 6'd30;
      bus.cmd_stride = 6'd1;
      @(posedge clk);
      #1;
      chk("hold_rsp_valid", bus.rsp_valid, 1);
      chk("hold_rd_vec", bus.rd_vec, rd);
      chk("hold_cmd_ready", bus.cmd_ready, 0);
      chk("hold_no_write", ram_write_enable, 0);
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    chk("rsp_valid_drop", bus.rsp_valid, 0);
    chk("cmd_ready_after_rsp", bus.cmd_ready, 1);
  endtask

  // Run a command and check it against the reference memory model.
  task automatic run_cmd(input bit wr, input logic [5:0] b, input logic [5:0] s,
                         input logic [31:0] wv, input int hold, output logic [31:0] rd);
    int          lat;
    int          bad;
    logic [31:0] exp;
    exp = model_load(b, s);
    do_cmd(wr, b, s, wv, hold, rd, lat);
    chk(wr ? "store_latency" : "load_latency", lat, wr ? 4 : 5);
    if (wr) begin
      chk("store_rd_unchanged", rd, last_rd);
      chk("store_write_count", waddr_log.size() - wlog_rd, 4);
      for (int i = 0; i < 4; i++) begin
        if (wlog_rd < waddr_log.size()) begin
          chk("store_write_addr", waddr_log[wlog_rd], lane_addr(b, s, i));
          wlog_rd++;
        end
      end
      for (int i = 0; i < 4; i++) ref_mem[lane_addr(b, s, i)] = wv[i*8 +: 8];
      bad = 0;
      for (int a = 0; a < 64; a++) if (mem[a] != ref_mem[a]) bad++;
      chk("store_mem_image_mismatches", bad, 0);
    end else begin
      chk("load_model_data", rd, exp);
      chk("load_no_writes", waddr_log.size() - wlog_rd, 0);
      last_rd = exp;
    end
  endtask

  vec_rec_t tbl[8];

  initial begin
    logic [31:0] rd;
    int          lat;
    checks   = 0;
    failures = 0;
    last_rd  = '0;
    wlog_rd  = 0;
    bus.cmd_valid  = 1'b0;
    bus.cmd_write  = 1'b0;
    bus.cmd_base   = '0;
    bus.cmd_stride = '0;
    bus.wr_vec     = '0;
    bus.rsp_ready  = 1'b0;

    // Reset values.
    #3;
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rd_vec", bus.rd_vec, 0);
    chk("rst_we", ram_write_enable, 0);
    chk("rst_waddr", ram_write_addr, 0);
    chk("rst_raddr", ram_read_addr, 0);
    chk("rst_data", ram_data, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table: {wr, base, stride, wr_vec, expected load data}.
    tbl[0] = '{1'b1, 6'd0,  6'd1, 32'h44332211, 32'h0};
    tbl[1] = '{1'b0, 6'd0,  6'd1, 32'h0,        32'h44332211};
    tbl[2] = '{1'b1, 6'd62, 6'd1, 32'hDDCCBBAA, 32'h0};
    tbl[3] = '{1'b0, 6'd62, 6'd1, 32'h0,        32'hDDCCBBAA};
    tbl[4] = '{1'b1, 6'd10, 6'd5, 32'h5A6B7C8D, 32'h0};
    tbl[5] = '{1'b0, 6'd10, 6'd5, 32'h0,        32'h5A6B7C8D};
    tbl[6] = '{1'b1, 6'd7,  6'd0, 32'h04030201, 32'h0};
    tbl[7] = '{1'b0, 6'd7,  6'd0, 32'h0,        32'h04040404};
    for (int t = 0; t < 8; t++) begin
      run_cmd(tbl[t].wr, tbl[t].base, tbl[t].stride, tbl[t].wv, 0, rd);
      if (!tbl[t].wr) chk($sformatf("table_load_%0d", t), rd, tbl[t].exp_rd);
      if (t == 0) begin
        chk("mem0", mem[0], 8'h11);
        chk("mem3", mem[3], 8'h44);
      end
      if (t == 2) begin
        chk("mem62", mem[62], 8'hAA);
        chk("mem1", mem[1], 8'hDD);
      end
    end
    chk("mem7_last_lane_wins", mem[7], 8'h04);
    chk("mem25_strided", mem[25], 8'h5A);

    // Held response with a stray command pulse during RESP.
    run_cmd(1'b0, 6'd10, 6'd5, 32'h0, 3, rd);
    chk("hold_load_data", rd, 32'h5A6B7C8D);
    chk("stray_cmd_no_writes", waddr_log.size() - wlog_rd, 0);
    chk("stray_cmd_idle", bus.cmd_ready, 1);

    // Reset in the middle of a store after two lanes have been written.
    @(negedge clk);
    bus.cmd_valid  = 1'b1;
    bus.cmd_write  = 1'b1;
    bus.cmd_base   = 6'd40;
    bus.cmd_stride = 6'd3;
    bus.wr_vec     = 32'hD4C3B2A1;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_we", ram_write_enable, 0);
    chk("midrst_waddr", ram_write_addr, 0);
    chk("midrst_data", ram_data, 0);
    chk("midrst_cmd_ready", bus.cmd_ready, 1);
    chk("midrst_rsp_valid", bus.rsp_valid, 0);
    chk("midrst_rd_vec", bus.rd_vec, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ref_mem[40] = 8'hA1;
    ref_mem[43] = 8'hB2;
    chk("midrst_lanes_written", waddr_log.size() - wlog_rd, 2);
    wlog_rd = waddr_log.size();
    last_rd = '0;
    chk("midrst_mem40", mem[40], ref_mem[40]);
    chk("midrst_mem43", mem[43], ref_mem[43]);
    chk("midrst_mem46_old", mem[46], ref_mem[46]);
    chk("midrst_mem49_old", mem[49], ref_mem[49]);
    repeat (2) @(negedge clk);
    chk("midrst_no_rsp", bus.rsp_valid, 0);

    // Randomised commands against the reference memory model.
    for (int r = 0; r < 30; r++) begin
      logic [5:0] rb, rs;
      rb = 6'($urandom_range(0, 63));
      rs = (r % 7 == 3) ? 6'd0 : 6'($urandom_range(0, 63));
      run_cmd(1'($urandom_range(0, 1)), rb, rs, $urandom, 0, rd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
